// File: rtl/logic_cluster_pkg.sv
// Shared types and config-layout helpers for the logic cluster.
package logic_cluster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL
    } ld_state_e;

    localparam int CFG_LUT_OFF = 0;

    function automatic int cfg_width(input int k);
        return (1 << k) + 2;
    endfunction

    function automatic int cfg_total(input int n, input int k);
        return n * cfg_width(k);
    endfunction

    function automatic int cfg_add_off(input int k);
        return 1 << k;
    endfunction

    function automatic int cfg_init_off(input int k);
        return (1 << k) + 1;
    endfunction

endpackage

// File: rtl/logic_cluster_cell.sv
// One cluster cell: K-input LUT or 1-bit full adder, carry link, output flop.
module logic_cluster_cell
    import logic_cluster_pkg::*;
#(
    parameter int LUT_K = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [cfg_width(LUT_K)-1:0] cfg,
    input  logic [LUT_K-1:0]            li,
    input  logic                        cin,
    input  logic                        cds,
    input  logic                        qdi,
    input  logic                        qen,
    input  logic                        qsts,
    input  logic                        qrts,
    input  logic                        load_init,
    input  logic                        init_new,
    output logic                        fz,
    output logic                        cout,
    output logic                        aqz
);

    localparam int TT_W = 1 << LUT_K;
    localparam int ADD_OFF = cfg_add_off(LUT_K);
    localparam int INIT_OFF = cfg_init_off(LUT_K);

    logic [TT_W-1:0] tt;
    logic            add_mode;
    logic            a;
    logic            b;
    logic            lut_out;
    logic            d_sel;
    logic            unused_init;

    assign tt       = cfg[CFG_LUT_OFF +: TT_W];
    assign add_mode = cfg[ADD_OFF];
    assign a        = li[0];
    assign b        = li[1];
    assign lut_out  = tt[li];

    // The active INIT bit only matters at commit, where the new value is used.
    assign unused_init = cfg[INIT_OFF];

    assign fz   = add_mode ? (a ^ b ^ cin) : lut_out;
    assign cout = add_mode ? ((a & b) | ((a ^ b) & cin)) : cin;

    assign d_sel = cds ? qdi : fz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aqz <= 1'b0;
        end else if (load_init) begin
            aqz <= init_new;
        end else if (qrts) begin
            aqz <= 1'b0;
        end else if (qsts) begin
            aqz <= 1'b1;
        end else if (qen) begin
            aqz <= d_sel;
        end
    end

endmodule

// File: rtl/logic_cluster.sv
// Logic cluster top: serial config loader, shadow/active config, cell array.
// Optional readback path enabled by LOGIC_CLUSTER_READBACK_EN.
module logic_cluster
    import logic_cluster_pkg::*;
#(
    parameter int NUM_CELLS = 4,
    parameter int LUT_K     = 4
) (
    input  logic                       QCK,
    input  logic                       QRT,
    input  logic [NUM_CELLS*LUT_K-1:0] LI,
    input  logic                       CI,
    input  logic [NUM_CELLS-1:0]       CDS,
    input  logic [NUM_CELLS-1:0]       QDI,
    input  logic [NUM_CELLS-1:0]       QEN,
    input  logic                       QSTS,
    input  logic                       QRTS,
    input  logic                       CFG_SI,
    input  logic                       CFG_SE,
    input  logic                       CFG_COMMIT,
    input  logic                       CFG_RB,
    output logic                       CFG_SO,
    output logic                       CFG_FULL,
    output logic                       CFG_ERR,
    output logic [NUM_CELLS-1:0]       FZ,
    output logic [NUM_CELLS-1:0]       AQZ,
    output logic                       CO
);

    localparam int W        = cfg_width(LUT_K);
    localparam int TOTAL    = cfg_total(NUM_CELLS, LUT_K);
    localparam int INIT_OFF = cfg_init_off(LUT_K);
    localparam int CW       = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [TOTAL-1:0] shadow;
    logic [TOTAL-1:0] active;
    logic [CW-1:0]    cnt;
    ld_state_e        state;
    logic             cfg_err;
    logic             commit_ok;
    logic [NUM_CELLS:0] carry;

    assign commit_ok = CFG_COMMIT && (state == ST_FULL);
    assign CFG_FULL  = (state == ST_FULL);
    assign CFG_ERR   = cfg_err;

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            shadow  <= '0;
            active  <= '0;
            cnt     <= '0;
            state   <= ST_IDLE;
            cfg_err <= 1'b0;
        end else begin
            if (CFG_SE) begin
                shadow <= {CFG_SI, shadow[TOTAL-1:1]};
            end
            if (CFG_COMMIT && !commit_ok) begin
                cfg_err <= 1'b1;
            end
            // Non-blocking copy captures the pre-shift shadow.
            if (commit_ok) begin
                active <= shadow;
            end
            unique case (state)
                ST_IDLE: begin
                    if (CFG_SE) begin
                        cnt   <= CNT_ONE;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (CFG_SE) begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt == CNT_LAST) begin
                            state <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (commit_ok) begin
                        cnt   <= CFG_SE ? CNT_ONE : '0;
                        state <= CFG_SE ? ST_LOAD : ST_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
`ifdef LOGIC_CLUSTER_READBACK_EN
            if (CFG_RB && !CFG_SE && !commit_ok) begin
                shadow <= active;
                cnt    <= CW'(TOTAL);
                state  <= ST_FULL;
            end
`endif
        end
    end

`ifdef LOGIC_CLUSTER_READBACK_EN
    assign CFG_SO = shadow[0];
`else
    logic unused_rb;
    assign unused_rb = CFG_RB;
    assign CFG_SO    = 1'b0;
`endif

    assign carry[0] = CI;
    assign CO       = carry[NUM_CELLS];

    for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
        logic cell_init;
        assign cell_init = shadow[c*W + INIT_OFF];

        logic_cluster_cell #(
            .LUT_K(LUT_K)
        ) u_cell (
            .clk      (QCK),
            .rst      (QRT),
            .cfg      (active[c*W +: W]),
            .li       (LI[c*LUT_K +: LUT_K]),
            .cin      (carry[c]),
            .cds      (CDS[c]),
            .qdi      (QDI[c]),
            .qen      (QEN[c]),
            .qsts     (QSTS),
            .qrts     (QRTS),
            .load_init(commit_ok),
            .init_new (cell_init),
            .fz       (FZ[c]),
            .cout     (carry[c+1]),
            .aqz      (AQZ[c])
        );
    end

endmodule

// File: tb/tb_logic_cluster.sv
// Directed bench for logic_cluster at NUM_CELLS=4, LUT_K=4 (72 config bits).
module tb_logic_cluster;

    logic        QCK = 1'b0;
    logic        QRT = 1'b1;
    logic [15:0] LI = '0;
    logic        CI = 1'b0;
    logic [3:0]  CDS = '0;
    logic [3:0]  QDI = '0;
    logic [3:0]  QEN = '0;
    logic        QSTS = 1'b0;
    logic        QRTS = 1'b0;
    logic        CFG_SI = 1'b0;
    logic        CFG_SE = 1'b0;
    logic        CFG_COMMIT = 1'b0;
    logic        CFG_RB = 1'b0;
    logic        CFG_SO;
    logic        CFG_FULL;
    logic        CFG_ERR;
    logic [3:0]  FZ;
    logic [3:0]  AQZ;
    logic        CO;

    int n_checks = 0;
    int n_fail = 0;

    always #5 QCK = ~QCK;

    logic_cluster #(
        .NUM_CELLS(4),
        .LUT_K(4)
    ) dut (
        .QCK(QCK), .QRT(QRT), .LI(LI), .CI(CI),
        .CDS(CDS), .QDI(QDI), .QEN(QEN),
        .QSTS(QSTS), .QRTS(QRTS),
        .CFG_SI(CFG_SI), .CFG_SE(CFG_SE),
        .CFG_COMMIT(CFG_COMMIT), .CFG_RB(CFG_RB),
        .CFG_SO(CFG_SO), .CFG_FULL(CFG_FULL), .CFG_ERR(CFG_ERR),
        .FZ(FZ), .AQZ(AQZ), .CO(CO)
    );

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [15:0] tt,
                                       input logic add, input logic init);
        return {init, add, tt};
    endfunction

    task automatic tick();
        @(posedge QCK);
        #1;
    endtask

    task automatic shift_in(input logic [71:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            CFG_SI = p[i];
            CFG_SE = 1'b1;
            tick();
        end
        CFG_SE = 1'b0;
        CFG_SI = 1'b0;
    endtask

    task automatic commit();
        CFG_COMMIT = 1'b1;
        tick();
        CFG_COMMIT = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [71:0] p_and, p_add, p_init, p_rb, got_so;

    initial begin
        p_and  = {4{mk(16'h8000, 1'b0, 1'b0)}};
        p_add  = {4{mk(16'h0000, 1'b1, 1'b0)}};
        p_init = {mk(16'h0, 1'b0, 1'b0), mk(16'h0, 1'b0, 1'b1),
                  mk(16'h0, 1'b0, 1'b0), mk(16'h0, 1'b0, 1'b0)};
        p_rb   = {mk(16'h1234, 1'b0, 1'b1), mk(16'hABCD, 1'b1, 1'b0),
                  mk(16'h0F0F, 1'b0, 1'b0), mk(16'hFFFF, 1'b1, 1'b1)};

        tick();
        tick();
        QRT = 1'b0;
        tick();
        check("rst_aqz", AQZ, 4'h0);
        check("rst_full", CFG_FULL, 1'b0);
        check("rst_err", CFG_ERR, 1'b0);
        check("rst_so", CFG_SO, 1'b0);
        LI = 16'hFFFF;
        CI = 1'b1;
        settle();
        check("rst_fz", FZ, 4'h0);
        check("rst_co", CO, 1'b1);

        // AND-of-all-inputs table in every cell
        shift_in(p_and, 72);
        check("and_full", CFG_FULL, 1'b1);
        commit();
        check("and_full_fall", CFG_FULL, 1'b0);
        check("and_aqz_init", AQZ, 4'h0);
        LI = 16'hF3F0;
        settle();
        check("and_fz_mix", FZ, 4'b1010);
        LI = 16'hFFFF;
        CI = 1'b1;
        settle();
        check("and_fz_all", FZ, 4'hF);
        check("and_co_pass", CO, 1'b1);

        // Adder mode
        shift_in(p_add, 72);
        commit();
        LI = 16'h1111;
        CI = 1'b1;
        settle();
        check("add_fz_ci1", FZ, 4'h0);
        check("add_co_ci1", CO, 1'b1);
        CI = 1'b0;
        settle();
        check("add_fz_ci0", FZ, 4'hF);
        check("add_co_ci0", CO, 1'b0);
        LI = 16'h3333;
        settle();
        check("add_fz_ab", FZ, 4'b1110);
        check("add_co_ab", CO, 1'b1);

        // Early commit is rejected
        shift_in(p_and, 71);
        check("err_not_full", CFG_FULL, 1'b0);
        commit();
        check("err_set", CFG_ERR, 1'b1);
        LI = 16'h1111;
        CI = 1'b0;
        settle();
        check("err_active_kept", FZ, 4'hF);
        shift_in(p_and >> 71, 1);
        check("err_full72", CFG_FULL, 1'b1);
        commit();
        check("err_sticky", CFG_ERR, 1'b1);
        LI = 16'hFFFF;
        settle();
        check("err_new_fz_f", FZ, 4'hF);
        LI = 16'h1111;
        settle();
        check("err_new_fz_1", FZ, 4'h0);

        // INIT and flop priority
        shift_in(p_init, 72);
        commit();
        check("init_aqz", AQZ, 4'b0100);
        QEN = 4'hF;
        CDS = 4'hF;
        QDI = 4'hA;
        tick();
        check("qdi_load", AQZ, 4'hA);
        QEN = 4'h0;
        QDI = 4'h5;
        tick();
        check("qen_hold", AQZ, 4'hA);
        QSTS = 1'b1;
        QRTS = 1'b1;
        tick();
        check("qrts_wins", AQZ, 4'h0);
        QRTS = 1'b0;
        tick();
        check("qsts_set", AQZ, 4'hF);
        QSTS = 1'b0;
        QEN = 4'hF;
        CDS = 4'h0;
        tick();
        check("qen_fz", AQZ, 4'h0);
        QSTS = 1'b1;
        QEN = 4'h0;
        tick();
        QSTS = 1'b0;

        // Async reset mid-load
        shift_in(p_add, 40);
        QRT = 1'b1;
        #1;
        check("mid_rst_full", CFG_FULL, 1'b0);
        check("mid_rst_cnt", dut.cnt, 0);
        check("mid_rst_aqz", AQZ, 4'h0);
        tick();
        QRT = 1'b0;
        check("mid_rst_err", CFG_ERR, 1'b0);
        shift_in(p_and, 72);
        commit();
        LI = 16'hF0FF;
        settle();
        check("fresh_fz", FZ, 4'b1011);

        // Commit and shift in the same cycle
        shift_in(p_add, 72);
        CFG_SE = 1'b1;
        CFG_SI = 1'b0;
        CFG_COMMIT = 1'b1;
        tick();
        CFG_SE = 1'b0;
        CFG_COMMIT = 1'b0;
        check("cs_full", CFG_FULL, 1'b0);
        check("cs_cnt", dut.cnt, 1);
        LI = 16'h1111;
        CI = 1'b0;
        settle();
        check("cs_fz", FZ, 4'hF);

        QRT = 1'b1;
        tick();
        QRT = 1'b0;
        shift_in(p_rb, 72);
        commit();
        shift_in({72{1'b1}}, 10);
        CFG_RB = 1'b1;
        tick();
        CFG_RB = 1'b0;
`ifdef LOGIC_CLUSTER_READBACK_EN
        check("rb_full", CFG_FULL, 1'b1);
        got_so = '0;
        for (int i = 0; i < 72; i++) begin
            got_so[i] = CFG_SO;
            CFG_SI = 1'b0;
            CFG_SE = 1'b1;
            tick();
        end
        CFG_SE = 1'b0;
        check("rb_stream", got_so, p_rb);
`else
        check("rb_ignored", CFG_FULL, 1'b0);
        check("so_tied", CFG_SO, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
